// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   GROUP_W        : bits handled by one CLA group (one pipeline stage)
//   OP_ADD/OP_SUB  : encoding of the sub input
//   stage_ctl_t    : control half of a stage register (valid, running carry,
//                    running group generate/propagate); the top wraps it with
//                    the WIDTH-dependent sum and operand fields
package cla_pkg;

  localparam int GROUP_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic valid;
    logic carry;
    logic g_acc;
    logic p_acc;
  } stage_ctl_t;

endpackage

// File: rtl/cla_4_group.sv
// Purely combinational 4-bit carry-lookahead slice.
//   a, b : 4-bit operands
//   cin  : carry into bit 0
//   sum  : 4-bit sum
//   cout : carry out of bit 3
//   g, p : group generate / propagate (independent of cin)
module cla_4_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       g,
  output logic       p
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  // Every internal carry is formed directly from gi/pi/cin, no ripple.
  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;

  assign cout = g | (p & cin);
  assign sum  = pi ^ c;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor, one 4-bit CLA group
// per stage, latency WIDTH/4 cycles, one beat per cycle with valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   a, b, cin, sub      : operands; result = a + (sub ? ~b : b) + cin
//   out_valid/out_ready : output handshake
//   sum, cout, ovf, zero: registered result and status flags
//   g_g, p_g            : whole-word group generate / propagate
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             g_g,
  output logic             p_g
);

  localparam int N  = WIDTH / GROUP_W;
  localparam int SN = (N > 1) ? N - 1 : 1;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of GROUP_W");
  end

  // Operands travel whole; stage k only consumes slice k. Sum bits are
  // filled in slice by slice as the beat moves down the pipe.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  logic   advance;
  stage_t head;
  stage_t nxt [N];
  stage_t stg [SN];
  stage_t last;
  logic   msb_carry;

  // The whole pipe moves in lockstep whenever the output slot is free.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~rst;

  always_comb begin
    head           = '0;
    head.ctl.valid = in_valid;
    head.ctl.carry = cin;
    head.ctl.g_acc = 1'b0;
    head.ctl.p_acc = 1'b1;
    head.a         = a;
    head.b         = (sub == OP_SUB) ? ~b : b;
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    stage_t             cur;
    stage_t             res;
    logic [GROUP_W-1:0] s;
    logic               co;
    logic               g;
    logic               p;

    if (k == 0) begin : g_first
      assign cur = head;
    end else begin : g_rest
      assign cur = stg[k-1];
    end

    cla_4_group u_group (
      .a    (cur.a[k*GROUP_W +: GROUP_W]),
      .b    (cur.b[k*GROUP_W +: GROUP_W]),
      .cin  (cur.ctl.carry),
      .sum  (s),
      .cout (co),
      .g    (g),
      .p    (p)
    );

    always_comb begin
      res                          = cur;
      res.sum[k*GROUP_W +: GROUP_W] = s;
      res.ctl.carry                = co;
      res.ctl.g_acc                = g | (p & cur.ctl.g_acc);
      res.ctl.p_acc                = cur.ctl.p_acc & p;
    end

    assign nxt[k] = res;
  end

  assign last = nxt[N-1];

  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign msb_carry = last.sum[WIDTH-1] ^ last.a[WIDTH-1] ^ last.b[WIDTH-1];

  // ---- stage registers _p0.._pN-2 and output register _pN-1 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N - 1; k++) begin
        stg[k].ctl.valid <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      g_g       <= 1'b0;
      p_g       <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < N - 1; k++) begin
        stg[k] <= nxt[k];
      end
      out_valid <= last.ctl.valid;
      // Bubbles leave the previous result in place so stale stage data
      // never reaches the outputs.
      if (last.ctl.valid) begin
        sum  <= last.sum;
        cout <= last.ctl.carry;
        ovf  <= msb_carry ^ last.ctl.carry;
        zero <= (last.sum == '0);
        g_g  <= last.ctl.g_acc;
        p_g  <= last.ctl.p_acc;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        g_g;
  logic        p_g;

  int tests  = 0;
  int failed = 0;
  int n_recv = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        gg;
    logic        pg;
  } res_t;

  res_t q[$];

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .g_g       (g_g),
    .p_g       (p_g)
  );

  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    res_t        r;
    logic [15:0] bx;
    logic [16:0] full;
    logic [16:0] nocin;
    bx    = ms ? ~mb : mb;
    full  = {1'b0, ma} + {1'b0, bx} + {16'd0, mc};
    nocin = {1'b0, ma} + {1'b0, bx};
    r.s   = full[15:0];
    r.co  = full[16];
    r.ov  = (ma[15] == bx[15]) && (full[15] != ma[15]);
    r.z   = (full[15:0] == 16'd0);
    r.gg  = nocin[16];
    r.pg  = &(ma ^ bx);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // One streaming cycle: score any beat leaving, record any beat entering.
  task automatic step(output logic accepted);
    res_t got;
    res_t exp;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("stream_beat_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp = q.pop_front();
        got = {sum, cout, ovf, zero, g_g, p_g};
        chk("stream_result", 32'(got), 32'(exp));
        n_recv++;
      end
    end
    if (accepted) q.push_back(model(a, b, cin, sub));
    tick();
  endtask

  task automatic drive(input logic [15:0] da, input logic [15:0] db,
                       input logic dc, input logic ds);
    in_valid = 1'b1;
    a        = da;
    b        = db;
    cin      = dc;
    sub      = ds;
  endtask

  // Single beat with hand-computed result; also pins latency to 4 cycles.
  task automatic directed(input string tag,
                          input logic [15:0] da, input logic [15:0] db,
                          input logic dc, input logic ds,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input logic ez, input logic egg, input logic epg);
    drive(da, db, dc, ds);
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_not_yet_c3"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid_c4"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    chk({tag, "_g_g"}, 32'(g_g), 32'(egg));
    chk({tag, "_p_g"}, 32'(p_g), 32'(epg));
    tick();
  endtask

  logic [15:0] thr_a   [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] thr_exp [4] = '{16'h1212, 16'h2323, 16'h3434, 16'h4545};
  logic [15:0] bp_a    [6] = '{16'h0001, 16'h1234, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0F0F};
  logic [15:0] bp_b    [6] = '{16'h0002, 16'h4321, 16'h8000, 16'h0001, 16'h7FFF, 16'hF0F0};

  initial begin
    logic acc;
    int   bi;
    int   n_sent;
    res_t front;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    tick();

    // Directed scenarios (values worked out by hand)
    directed("carry_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1, 0, 1, 1, 0);
    idle(2);
    directed("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 0, 1, 0, 0, 0);
    idle(2);
    directed("sub_5_7",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 0, 0, 0, 0, 0);
    idle(2);
    directed("prop_cin0",  16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 0, 0, 0, 0, 1);
    idle(2);
    directed("prop_cin1",  16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1, 0, 1, 0, 1);
    idle(3);

    // Throughput: four back-to-back beats out in cycles 4..7
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(thr_a[i], 16'h0101, 1'b0, 1'b0);
      else in_valid = 1'b0;
      #1;
      chk("thr_in_ready", 32'(in_ready), 32'd1);
      if (i >= 4) begin
        chk("thr_out_valid", 32'(out_valid), 32'd1);
        chk("thr_sum", 32'(sum), 32'(thr_exp[i-4]));
      end else begin
        chk("thr_no_early_out", 32'(out_valid), 32'd0);
      end
      tick();
    end
    idle(3);

    // Backpressure: stall on first result, then drain in order
    q.delete();
    n_recv = 0;
    bi = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && !out_valid; c++) begin
      drive(bp_a[bi], bp_b[bi], 1'(bi & 1), 1'(bi >> 1 & 1));
      step(acc);
      if (acc) bi++;
    end
    chk("bp_out_valid_rise", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    drive(bp_a[bi], bp_b[bi], 1'(bi & 1), 1'(bi >> 1 & 1));
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step(acc);
      chk("bp_no_accept", 32'(acc), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      front = (q.size() != 0) ? q[0] : '0;
      chk("bp_hold_result", 32'({sum, cout, ovf, zero, g_g, p_g}), 32'(front));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (bi < 6 || q.size() != 0); c++) begin
      if (bi < 6) drive(bp_a[bi], bp_b[bi], 1'(bi & 1), 1'(bi >> 1 & 1));
      else in_valid = 1'b0;
      step(acc);
      if (acc) bi++;
    end
    chk("bp_all_received", 32'(n_recv), 32'd6);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);
    idle(3);

    // Reset with three beats in flight
    q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(16'h0100 + 16'(i), 16'h0010, 1'b0, 1'b0);
      step(acc);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_outputs", 32'({sum, cout, ovf, zero, g_g, p_g}), 32'd0);
    #1;
    chk("mid_rst_in_ready_back", 32'(in_ready), 32'd1);
    q.delete();
    for (int c = 0; c < 8; c++) begin
      step(acc);
      chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end
    directed("after_rst", 16'h1234, 16'h0FFF, 1'b1, 1'b1, 16'h0235, 1, 0, 0, 1, 0);
    idle(3);

    // Randomised sweep with random stalls on both sides
    q.delete();
    n_recv = 0;
    n_sent = 0;
    for (int c = 0; c < 800 && (n_sent < 40 || q.size() != 0); c++) begin
      if (n_sent < 40 && $urandom_range(0, 3) != 0)
        drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) n_sent++;
    end
    chk("sweep_sent", 32'(n_sent), 32'd40);
    chk("sweep_received", 32'(n_recv), 32'd40);
    chk("sweep_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
